stage_pipe_reg: RTL and testbench
=================================

# stage_pipe_reg

- Parametrised pipeline stage register; successor to the fixed fetch/decode delay register.
- Carries instruction and PC payload between any two core pipeline stages under a valid/ready handshake.
- Supports flush to a NOP bubble, external stall, an optional skid entry for full throughput with registered ready, and a saturating stall-cycle counter.
- One instance sits between each pair of adjacent stages (F/D, D/E, E/M, M/W).

## Interface
Parameters:
- INST_W, 32, instruction payload width
- ADDR_W, 32, PC payload width
- NOP_INST, 32'h0000_0013 (addi x0,x0,0), payload loaded on reset and on flush
- RESET_PC, 0, PC payload after reset
- CNT_W, 16, stall counter width

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_n_i  in  1  reset; asynchronous, active-low
- flush_i  in  1  discard all held entries; highest priority
- stall_i  in  1  freeze stage; nothing leaves while high
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  stage can accept
- in_inst_i  in  INST_W  upstream instruction
- in_pc_i  in  ADDR_W  upstream PC
- out_valid_o  out  1  payload valid toward downstream
- out_ready_i  in  1  downstream can accept
- out_inst_o  out  INST_W  held instruction
- out_pc_o  out  ADDR_W  held PC
- stall_cnt_o  out  CNT_W  saturating count of held-valid cycles

## Operation
- State: main entry (valid_q, inst_q, pc_q); with STAGE_SKID_EN also a skid entry (skid_v, skid_inst, skid_pc); counter cnt_q.
- Outputs are driven from the main entry:
  - out_valid_o = valid_q & ~stall_i
  - out_inst_o = inst_q
  - out_pc_o = pc_q
- Handshake events:
  - accept = in_valid_i & in_ready_o
  - consume = out_valid_o & out_ready_i
- Payload must not change while valid_q=1 and consume=0.
- Reset (asynchronous, rst_n_i=0): valid_q=0, inst_q=NOP_INST, pc_q=RESET_PC, skid_v=0, cnt_q=0. Resulting outputs: out_valid_o=0, out_inst_o=NOP_INST, out_pc_o=RESET_PC, stall_cnt_o=0. in_ready_o=1 once out of reset.
- Flush (flush_i=1):
  - Next state: valid_q=0, skid_v=0, inst_q=NOP_INST, pc_q unchanged.
  - Any accept in the same cycle completes the handshake upstream but is discarded.
  - Flush wins over stall, accept and consume.
- Normal update, no flush, main entry:
  - Loads accepted data when it is empty or being consumed.
  - Otherwise holds.
  - valid_q clears when consumed with nothing to load.
- Skid (STAGE_SKID_EN only):
  - An accept while the main entry is valid and not consumed writes the skid entry.
  - A consume with skid_v=1 moves skid into main; a simultaneous accept then writes skid.
  - The two entries are never both loaded from the same input.
- Stall counter:
  - cnt_q increments each cycle with valid_q=1 and consume=0 (covers both stall_i and ~out_ready_i).
  - Saturates at 2^CNT_W-1.
  - Unaffected by flush; cleared only by reset.

## Timing
- Latency: accept in cycle N gives out_valid_o in cycle N+1.
- Throughput: one transfer per cycle when out_ready_i=1 and stall_i=0.
- stall_i is seen on out_valid_o combinationally, in the same cycle.
- in_ready_o path:
  - Without skid: combinational from out_ready_i/stall_i.
  - With skid: flop-only.
- Flush asserted in cycle N: out_valid_o=0 and out_inst_o=NOP_INST from cycle N+1.
- Reset deasserted mid-stream: the first accept is the earliest legal transfer; entries in flight before reset are lost.

## Configuration
- STAGE_SKID_EN defined:
  - Two-entry buffer.
  - in_ready_o = ~skid_v (registered).
  - Full rate is sustained without a combinational ready chain across stages.
- STAGE_SKID_EN undefined:
  - Single entry.
  - in_ready_o = ~valid_q | (out_ready_i & ~stall_i) (combinational).
  - Skid state is not built.
- Cycle-level output sequence is identical in both builds for any stimulus that never backpressures.

## Structure
- Shared in core_param.v:
  - `INST_NOP` (addi x0 encoding), used as NOP_INST default
  - `InstAddrBus`
  - `PLFLUSH_ENABLE` and `PC_STOP_ENABLE` level constants, used when wiring flush_i/stall_i
- One natural sub-module: stage_skid_entry, a single holding register with load/clear/valid. It is instantiated for the main entry, and for the skid entry under STAGE_SKID_EN.

## Test plan
- Reset then stream inst 0x00A00093..0x00A000F3 (PC 0x0,0x4,…) with out_ready_i=1 -> each appears one cycle later; one per cycle; stall_cnt_o stays 0.
- Hold out_ready_i=0 for 3 cycles with a valid payload -> payload stable, stall_cnt_o=3.
  - Skid build: one extra input absorbed, then in_ready_o=0.
  - No-skid build: in_ready_o=0 immediately.
- flush_i=1 while holding PC 0x40 (and skid PC 0x44) -> next cycle out_valid_o=0, out_inst_o=0x00000013, out_pc_o=0x40; the input accepted in the flush cycle never emerges.
- Assert stall_i and flush_i together -> flush wins; stage empty next cycle.
- Stall for 2^CNT_W+5 cycles (CNT_W=4) -> stall_cnt_o saturates at 15.
- Pull rst_n_i low mid-transfer, asynchronously between edges -> outputs go immediately to reset values: out_valid_o=0, NOP_INST, RESET_PC, stall_cnt_o=0.

Source files
------------

// File: rtl/stage_pipe_reg_pkg.sv
// Shared constants for the core pipeline stage registers: NOP encoding,
// instruction-address bus width and the active levels of flush/stall.
package stage_pipe_reg_pkg;

  localparam logic [31:0] INST_NOP        = 32'h0000_0013;
  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam logic        PLFLUSH_ENABLE  = 1'b1;
  localparam logic        PC_STOP_ENABLE  = 1'b1;

  // Main entry may take new data when it is empty or draining this cycle.
  function automatic logic main_can_load(input logic valid, input logic consume);
    return (~valid) | consume;
  endfunction

endpackage

// File: rtl/stage_skid_entry.sv
// One holding register (valid + instruction + PC) with flush, load and drop.
// Flush wins over load, load wins over drop; a drop keeps the payload.
module stage_skid_entry #(
  parameter int unsigned        INST_W   = 32,
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = {INST_W{1'b0}},
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic              valid_r;
  logic [INST_W-1:0] inst_r;
  logic [ADDR_W-1:0] pc_r;

  // Entry state; a flush turns the slot into a NOP bubble but keeps the PC.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_r <= 1'b0;
      inst_r  <= NOP_INST;
      pc_r    <= RESET_PC;
    end else if (flush_i) begin
      valid_r <= 1'b0;
      inst_r  <= NOP_INST;
    end else if (load_i) begin
      valid_r <= 1'b1;
      inst_r  <= inst_i;
      pc_r    <= pc_i;
    end else if (drop_i) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid_o = valid_r;
  assign inst_o  = inst_r;
  assign pc_o    = pc_r;

endmodule

// File: rtl/stage_pipe_reg.sv
// Valid/ready pipeline stage register with flush, stall and a saturating
// stall counter. Define STAGE_SKID_EN for a second (skid) entry and registered ready.
module stage_pipe_reg
  import stage_pipe_reg_pkg::*;
#(
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       ADDR_W   = INST_ADDR_BUS_W,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(INST_NOP),
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [INST_W-1:0] in_inst_i,
  input  logic [ADDR_W-1:0] in_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [INST_W-1:0] out_inst_o,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              flush_s;
  logic              stall_s;
  logic              accept_s;
  logic              consume_s;
  logic              main_valid_s;
  logic [INST_W-1:0] main_inst_s;
  logic [ADDR_W-1:0] main_pc_s;
  logic              main_load_s;
  logic              main_drop_s;
  logic [INST_W-1:0] main_inst_nxt_s;
  logic [ADDR_W-1:0] main_pc_nxt_s;
  logic [CNT_W-1:0]  cnt_r;

  assign flush_s     = (flush_i == PLFLUSH_ENABLE);
  assign stall_s     = (stall_i == PC_STOP_ENABLE);
  assign out_valid_o = main_valid_s & ~stall_s;
  assign out_inst_o  = main_inst_s;
  assign out_pc_o    = main_pc_s;
  assign accept_s    = in_valid_i & in_ready_o;
  assign consume_s   = out_valid_o & out_ready_i;

  stage_skid_entry #(
    .INST_W   (INST_W),
    .ADDR_W   (ADDR_W),
    .NOP_INST (NOP_INST),
    .RESET_PC (RESET_PC)
  ) u_main (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_s),
    .load_i  (main_load_s),
    .drop_i  (main_drop_s),
    .inst_i  (main_inst_nxt_s),
    .pc_i    (main_pc_nxt_s),
    .valid_o (main_valid_s),
    .inst_o  (main_inst_s),
    .pc_o    (main_pc_s)
  );

`ifdef STAGE_SKID_EN
  logic              skid_valid_s;
  logic [INST_W-1:0] skid_inst_s;
  logic [ADDR_W-1:0] skid_pc_s;
  logic              skid_load_s;
  logic              skid_drop_s;

  stage_skid_entry #(
    .INST_W   (INST_W),
    .ADDR_W   (ADDR_W),
    .NOP_INST (NOP_INST),
    .RESET_PC (RESET_PC)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_s),
    .load_i  (skid_load_s),
    .drop_i  (skid_drop_s),
    .inst_i  (in_inst_i),
    .pc_i    (in_pc_i),
    .valid_o (skid_valid_s),
    .inst_o  (skid_inst_s),
    .pc_o    (skid_pc_s)
  );

  // Ready depends only on the skid flop, so no ready chain forms across stages.
  assign in_ready_o = ~skid_valid_s;

  // Main refills from skid first; the input goes to skid only when main keeps its data.
  always_comb begin
    main_load_s     = 1'b0;
    main_inst_nxt_s = in_inst_i;
    main_pc_nxt_s   = in_pc_i;
    if (main_can_load(main_valid_s, consume_s) && (skid_valid_s || accept_s)) begin
      main_load_s = 1'b1;
      if (skid_valid_s) begin
        main_inst_nxt_s = skid_inst_s;
        main_pc_nxt_s   = skid_pc_s;
      end else begin
        main_inst_nxt_s = in_inst_i;
        main_pc_nxt_s   = in_pc_i;
      end
    end else begin
      main_load_s = 1'b0;
    end
    main_drop_s = consume_s & ~main_load_s;
    skid_load_s = accept_s & main_valid_s & (~consume_s | skid_valid_s);
    skid_drop_s = consume_s & skid_valid_s & ~skid_load_s;
  end
`else
  assign in_ready_o = main_can_load(main_valid_s, out_ready_i & ~stall_s);

  // Single entry: every accept lands in main, which is free by construction.
  always_comb begin
    main_load_s     = accept_s;
    main_inst_nxt_s = in_inst_i;
    main_pc_nxt_s   = in_pc_i;
    main_drop_s     = consume_s & ~accept_s;
  end
`endif

  // Cycles with a held payload that did not leave; saturates, only reset clears it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (main_valid_s && !consume_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign stall_cnt_o = cnt_r;

endmodule

// File: tb/tb_stage_pipe_reg.sv
// Scoreboard bench for stage_pipe_reg (CNT_W=4): a queue holds the payloads
// the stage should contain; each cycle its state predicts the DUT outputs.
module tb_stage_pipe_reg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } item_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        stall;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [3:0]  stall_cnt;

  item_t sb[$];
  int    cnt_m;
  int    n_vec;
  int    n_err;
  logic  acc;

  stage_pipe_reg #(.CNT_W(4)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .stall_i     (stall),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_inst_i   (in_inst),
    .in_pc_i     (in_pc),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_inst_o  (out_inst),
    .out_pc_o    (out_pc),
    .stall_cnt_o (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one cycle (called at posedge+1), checks at negedge, updates the model.
  task automatic run_cycle(input logic fl, input logic st, input logic iv,
                           input logic [31:0] ii, input logic [31:0] ip,
                           input logic ordy, output logic acc_o);
    logic exp_v;
    logic exp_r;
    logic cons;
    item_t it;
    flush = fl; stall = st; in_valid = iv; in_inst = ii; in_pc = ip; out_ready = ordy;
    @(negedge clk);
    exp_v = (sb.size() != 0) && !st;
`ifdef STAGE_SKID_EN
    exp_r = (sb.size() < 2);
`else
    exp_r = (sb.size() == 0) || (ordy && !st);
`endif
    check_val("out_valid", 32'(out_valid), 32'(exp_v));
    check_val("in_ready", 32'(in_ready), 32'(exp_r));
    check_val("stall_cnt", 32'(stall_cnt), 32'(cnt_m));
    if (sb.size() != 0) begin
      check_val("out_inst", out_inst, sb[0].inst);
      check_val("out_pc", out_pc, sb[0].pc);
    end
    acc_o = iv && exp_r;
    cons  = exp_v && ordy;
    if (sb.size() != 0 && !cons && cnt_m != 15) cnt_m++;
    if (fl) begin
      sb.delete();
    end else begin
      if (cons) void'(sb.pop_front());
      if (acc_o) begin
        it.inst = ii;
        it.pc   = ip;
        sb.push_back(it);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    n_vec = 0; n_err = 0; cnt_m = 0;
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    in_inst = 32'h0; in_pc = 32'h0; out_ready = 1'b0;

    // Reset values
    @(negedge clk);
    check_val("rst_valid", 32'(out_valid), 32'h0);
    check_val("rst_inst", out_inst, 32'h0000_0013);
    check_val("rst_pc", out_pc, 32'h0);
    check_val("rst_cnt", 32'(stall_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_val("ready_after_rst", 32'(in_ready), 32'h1);

    // Full-rate stream, each item one cycle later
    for (int i = 0; i < 7; i++)
      run_cycle(1'b0, 1'b0, 1'b1, 32'h00A0_0093 + 32'(i) * 32'h10, 32'(i) * 32'h4, 1'b1, acc);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
    check_val("stream_cnt", 32'(stall_cnt), 32'h0);

    // Backpressure for three cycles with upstream still offering data
    run_cycle(1'b0, 1'b0, 1'b1, 32'h00B0_0093, 32'h20, 1'b1, acc);
    idx = 1;
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 1'b0, 1'b1, 32'h00B0_0093 + 32'(idx) * 32'h10, 32'h20 + 32'(idx) * 32'h4, 1'b0, acc);
      if (acc) idx++;
    end
    check_val("hold_cnt", 32'(stall_cnt), 32'h3);
`ifdef STAGE_SKID_EN
    check_val("hold_absorbed", 32'(idx), 32'h2);
`else
    check_val("hold_absorbed", 32'(idx), 32'h1);
`endif
    check_val("hold_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++)
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);

    // Flush while holding PC 0x40 (skid build also 0x44); flush-cycle input is lost
    run_cycle(1'b0, 1'b0, 1'b1, 32'h00C0_0093, 32'h40, 1'b0, acc);
    run_cycle(1'b0, 1'b0, 1'b1, 32'h00C0_00A3, 32'h44, 1'b0, acc);
    run_cycle(1'b1, 1'b0, 1'b1, 32'h00C0_00B3, 32'h48, 1'b1, acc);
    check_val("flush_valid", 32'(out_valid), 32'h0);
    check_val("flush_inst", out_inst, 32'h0000_0013);
    check_val("flush_pc", out_pc, 32'h40);
    for (int i = 0; i < 3; i++)
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);

    // Flush together with stall
    run_cycle(1'b0, 1'b0, 1'b1, 32'h00D0_0093, 32'h50, 1'b1, acc);
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, acc);
    check_val("flush_stall_valid", 32'(out_valid), 32'h0);
    check_val("flush_stall_inst", out_inst, 32'h0000_0013);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);

    // Long stall saturates the 4-bit counter
    run_cycle(1'b0, 1'b0, 1'b1, 32'h00E0_0093, 32'h60, 1'b1, acc);
    for (int i = 0; i < 21; i++)
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, acc);
    check_val("sat_cnt", 32'(stall_cnt), 32'hF);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);

    // Asynchronous reset between edges mid-transfer
    run_cycle(1'b0, 1'b0, 1'b1, 32'h00F0_0093, 32'h70, 1'b0, acc);
    in_inst = 32'h00F0_00A3; in_pc = 32'h74;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", 32'(out_valid), 32'h0);
    check_val("arst_inst", out_inst, 32'h0000_0013);
    check_val("arst_pc", out_pc, 32'h0);
    check_val("arst_cnt", 32'(stall_cnt), 32'h0);
    sb.delete();
    cnt_m = 0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
    run_cycle(1'b0, 1'b0, 1'b1, 32'h00F0_00B3, 32'h78, 1'b1, acc);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
